if_fetch_stage: RTL and testbench

Instruction fetch stage of the 64-bit RISC-V pipeline. It owns the program counter and issues in-order word requests to instruction memory over a valid/ready interface. Returned instructions are buffered with their PCs in a small FIFO and presented to the decode stage, which feeds the immediate generator and register file. A redirect input from branch/jump resolution flushes all in-flight and buffered work and restarts fetch at a new PC.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/if_fetch_stage_if.sv | 34 +++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/if_fetch_stage.sv | 96 +++++++++
 tb/tb_if_fetch_stage.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 64-bit RISC-V pipeline: machine widths,
// base opcodes used by decode/immediate generation, and the fetch entry type.
package cpu_pkg;

  localparam int XLEN        = 64;
  localparam int ILEN        = 32;
  localparam int INSTR_BYTES = 4;

  // Major opcodes (instr[6:0]) of RV64I.
  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_OP_IMM32 = 7'b0011011,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_OP32     = 7'b0111011,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  // One buffered fetch result: the instruction and the PC it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Sequential PC; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/response and decode handoff.
// The master modport is the fetch stage; the slave modport is its environment.
interface if_fetch_stage_if;
  import cpu_pkg::*;

  logic            imem_req_valid_o;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_req_ready_i;
  logic            imem_rsp_valid_i;
  logic [ILEN-1:0] imem_rsp_instr_i;
  logic            redirect_valid_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            id_valid_o;
  logic            id_ready_i;
  logic [ILEN-1:0] id_instr_o;
  logic [XLEN-1:0] id_pc_o;

  modport master (
    output imem_req_valid_o, imem_req_addr_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_instr_i,
    input  redirect_valid_i, redirect_pc_i,
    output id_valid_o, id_instr_o, id_pc_o,
    input  id_ready_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_instr_i,
    output redirect_valid_i, redirect_pc_i,
    input  id_valid_o, id_instr_o, id_pc_o,
    output id_ready_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous circular-buffer FIFO with clear and occupancy count.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module fetch_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear and reset empty the FIFO.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage.
  // NOTE: storage has no reset; validity is carried entirely by count/pointers.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order word requests under a
// credit limit, buffers returned words with their PCs, and flushes on redirect.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  if_fetch_stage_if.master  bus
);

  localparam int          CW      = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] req_pc, rsp_pc;
  logic [CW-1:0]   inflight, inflight_next;
  logic [CW-1:0]   drop, drop_next;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     demand;
  logic            fifo_full, fifo_empty;
  logic            redirect, req_fire, rsp, pop, push;
  fetch_entry_t    head, wentry;

  assign redirect = bus.redirect_valid_i;
  assign rsp      = bus.imem_rsp_valid_i;

  // Decode handoff: head of FIFO, suppressed in a redirect cycle.
  assign bus.id_valid_o = !fifo_empty && !redirect;
  assign bus.id_instr_o = head.instr;
  assign bus.id_pc_o    = head.pc;
  assign pop            = bus.id_valid_o && bus.id_ready_i;

  // Credit: owed responses plus buffered entries (after this cycle's pop) must
  // stay below DEPTH, so every returned word is guaranteed a FIFO slot.
  assign demand = (CW+1)'(inflight) + (CW+1)'(fifo_count) - (CW+1)'(pop);

  assign bus.imem_req_valid_o = !rst_i && !redirect && (demand < DEPTH_W);
  assign bus.imem_req_addr_o  = req_pc;
  assign req_fire             = bus.imem_req_valid_o && bus.imem_req_ready_i;

  // Next-state of the owed/discard counters and the push decision.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    inflight_next = inflight + CW'(req_fire) - CW'(rsp);
    drop_next     = drop;
    push          = 1'b0;
    if (redirect) begin
      // Everything still owed after this edge belongs to the old stream.
      drop_next = inflight_next;
    end else if (rsp) begin
      if (drop != '0) drop_next = drop - CW'(1);
      else            push      = !fifo_full;
    end
  end

  // PC and counter state; redirect overrides normal advance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_pc   <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_next;
      drop     <= drop_next;
      if (redirect) begin
        req_pc <= bus.redirect_pc_i;
        rsp_pc <= bus.redirect_pc_i;
      end else begin
        if (req_fire) req_pc <= next_pc(req_pc);
        if (push)     rsp_pc <= next_pc(rsp_pc);
      end
    end
  end

  assign wentry = '{pc: rsp_pc, instr: bus.imem_rsp_instr_i};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clear (redirect),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage. A transaction-level memory model and
// an expected-PC-stream model predict every request address and decode output.
module tb_if_fetch_stage;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          DEPTH    = 2;

  logic clk;
  logic rst;

  if_fetch_stage_if bus();

  if_fetch_stage #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
    int          epoch;
  } mem_txn_t;

  mem_txn_t    q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          last_due    = 0;
  int          epoch       = 0;
  int          buffered    = 0;
  int          lat_lo      = 1;
  int          lat_hi      = 1;
  logic [63:0] exp_pc;
  logic [63:0] exp_req;

  // Memory contents: a bijective scramble of the address.
  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    buffered = 0;
    epoch++;
    last_due = cyc;
    exp_pc   = RESET_PC;
    exp_req  = RESET_PC;
  endtask

  // Two reset cycles; outputs must be idle by the second one.
  task automatic do_reset();
    rst = 1'b1;
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_instr_i = '0;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = '0;
    bus.id_ready_i       = 1'b0;
    @(negedge clk);
    check("rst_req_valid_0", 64'(bus.imem_req_valid_o), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_req_valid_1", 64'(bus.imem_req_valid_o), 64'd0);
    check("rst_id_valid", 64'(bus.id_valid_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc += 2;
    model_reset();
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance model.
  task automatic step(input logic rdy, input logic idr, input logic redir, input logic [63:0] rpc);
    logic    rsp_now, exp_idv, exp_reqv, pop_exp, live;
    mem_txn_t e;
    int      due;
    rsp_now = (q.size() > 0) && (q[0].due <= cyc);
    bus.imem_req_ready_i = rdy;
    bus.id_ready_i       = idr;
    bus.redirect_valid_i = redir;
    bus.redirect_pc_i    = rpc;
    bus.imem_rsp_valid_i = rsp_now;
    bus.imem_rsp_instr_i = rsp_now ? instr_of(q[0].addr) : $urandom;
    @(negedge clk);
    exp_idv  = (buffered > 0) && !redir;
    pop_exp  = exp_idv && idr;
    exp_reqv = !redir && ((q.size() + buffered - int'(pop_exp)) < DEPTH);
    check("id_valid", 64'(bus.id_valid_o), 64'(exp_idv));
    check("req_valid", 64'(bus.imem_req_valid_o), 64'(exp_reqv));
    if (exp_reqv) check("req_addr", bus.imem_req_addr_o, exp_req);
    if (pop_exp) begin
      check("id_pc", bus.id_pc_o, exp_pc);
      check("id_instr", 64'(bus.id_instr_o), 64'(instr_of(exp_pc)));
      exp_pc += 64'd4;
    end
    live = 1'b0;
    if (rsp_now) begin
      e = q.pop_front();
      live = (e.epoch == epoch) && !redir;
    end
    buffered = buffered + int'(live) - int'(pop_exp);
    if (redir) begin
      buffered = 0;
      epoch++;
      exp_pc  = rpc;
      exp_req = rpc;
    end
    if (exp_reqv && rdy) begin
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      q.push_back('{addr: exp_req, due: due, epoch: epoch});
      exp_req += 64'd4;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_instr_i = '0;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = '0;
    bus.id_ready_i       = 1'b0;
    exp_pc  = RESET_PC;
    exp_req = RESET_PC;
    @(posedge clk); #1;
    do_reset();

    // Ideal memory, decode always ready: one instruction per cycle.
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Decode stall for 6 cycles, then release.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Memory backpressure pattern 1,0,0,1.
    for (int r = 0; r < 3; r++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 1'b0, '0);
    end

    // Redirect to 0x100 with two requests in flight at 3-cycle latency.
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (q.size() == 2) begin
        step(1'b1, 1'b1, 1'b1, 64'h100);
        found = 1'b1;
      end else begin
        step(1'b1, 1'b1, 1'b0, '0);
      end
    end
    check("redir_two_inflight_found", 64'(found), 64'd1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Redirect coinciding with a response and a would-be pop.
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (buffered > 0 && q.size() > 0 && q[0].due <= cyc) begin
        step(1'b1, 1'b1, 1'b1, 64'h200);
        found = 1'b1;
      end else begin
        step(1'b1, 1'b1, 1'b0, '0);
      end
    end
    check("redir_coincident_found", 64'(found), 64'd1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0);

    // PC wrap across 2^64.
    step(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Randomised traffic with a mid-stream reset.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        do_reset();
      end else begin
        step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 20) == 0,
             {$urandom, $urandom} & ~64'h3);
      end
    end

    // Back-to-back redirects: the last one wins.
    step(1'b1, 1'b1, 1'b1, 64'h4000);
    step(1'b1, 1'b1, 1'b1, 64'h8000);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
